// File: rtl/lab9_pio_pkg.sv
// lab9_pio_pkg: register offsets and edge-type encoding for the lab9 PIO
package lab9_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_IRQMASK = 3'd1;
   localparam logic [2:0] ADDR_EDGECAP = 3'd2;
   localparam logic [2:0] ADDR_OUTSET  = 3'd3;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd4;
   localparam logic [2:0] ADDR_OUTRB   = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_t;

endpackage

// File: rtl/lab9_pio_sync.sv
// lab9_pio_sync: per-bit 2-FF input synchronizer; with LAB9_PIO_EDGE_IRQ_EN a
// third "previous" stage and an EDGE_TYPE-selected edge detector are added
module lab9_pio_sync
   import lab9_pio_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int EDGE_TYPE  = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] i_d,
`ifdef LAB9_PIO_EDGE_IRQ_EN
   output logic [DATA_WIDTH-1:0] o_edge,
`endif
   output logic [DATA_WIDTH-1:0] o_sync
);

   logic [DATA_WIDTH-1:0] r_s1, r_s2;

   // two-stage metastability filter on the asynchronous inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_sync = r_s2;

`ifdef LAB9_PIO_EDGE_IRQ_EN
   logic [DATA_WIDTH-1:0] r_prev;

   // previous value of the synchronized input, for edge comparison
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_prev <= '0;
      else          r_prev <= r_s2;
   end

   // one-cycle edge pulse per bit in the configured sense
   always_comb begin
      o_edge = (EDGE_TYPE == int'(EDGE_FALL)) ? (~r_s2 & r_prev) :
               (EDGE_TYPE == int'(EDGE_ANY))  ? (r_s2 ^ r_prev)  :
                                                (r_s2 & ~r_prev);
   end
`endif

endmodule

// File: rtl/lab9_soc_pio_gen2.sv
// lab9_soc_pio_gen2: Avalon-MM parallel I/O with set/clear output access;
// LAB9_PIO_EDGE_IRQ_EN enables edge capture, IRQ mask and level irq
module lab9_soc_pio_gen2
   import lab9_pio_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          EDGE_TYPE   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_wd, w_sync, w_rd;
   logic [DATA_WIDTH-1:0] r_out;

   assign w_wr = chipselect & ~write_n;
   assign w_wd = writedata[DATA_WIDTH-1:0];

`ifdef LAB9_PIO_EDGE_IRQ_EN
   logic [DATA_WIDTH-1:0] w_edge, w_clr;
   logic [DATA_WIDTH-1:0] r_mask, r_cap;

   lab9_pio_sync #(.DATA_WIDTH(DATA_WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (in_port),
      .o_edge  (w_edge),
      .o_sync  (w_sync)
   );

   assign w_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

   // interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            r_mask <= '0;
      else if (w_wr && address == ADDR_IRQMASK) r_mask <= w_wd;
   end

   // sticky edge capture; a fresh edge outranks a same-cycle W1C
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cap <= '0;
      else          r_cap <= (r_cap & ~w_clr) | w_edge;
   end

   assign irq = |(r_cap & r_mask);
`else
   lab9_pio_sync #(.DATA_WIDTH(DATA_WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (in_port),
      .o_sync  (w_sync)
   );

   assign irq = 1'b0;
`endif

   // output register: direct load, bit set and bit clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           r_out <= RESET_VALUE[DATA_WIDTH-1:0];
      else if (w_wr && address == ADDR_DATA)   r_out <= w_wd;
      else if (w_wr && address == ADDR_OUTSET) r_out <= r_out | w_wd;
      else if (w_wr && address == ADDR_OUTCLR) r_out <= r_out & ~w_wd;
   end

   assign out_port = r_out;

   // zero-wait-state read mux, zero-extended onto the 32-bit bus
   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA:    w_rd = w_sync;
`ifdef LAB9_PIO_EDGE_IRQ_EN
         ADDR_IRQMASK: w_rd = r_mask;
         ADDR_EDGECAP: w_rd = r_cap;
`endif
         ADDR_OUTRB:   w_rd = r_out;
         default:      w_rd = '0;
      endcase
      readdata = '0;
      readdata[DATA_WIDTH-1:0] = w_rd;
   end

endmodule

// File: doc/lab9_soc_pio_gen2.md
LAB9_SOC_PIO_GEN2 -- requirements
Module: lab9_soc_pio_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, legal range 1..32, width of out_port and in_port.
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output data register (low DATA_WIDTH bits used).
REQ-003 Parameter EDGE_TYPE, default 0, edge-capture sense: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero wait state.
REQ-011 in_port  input  DATA_WIDTH  asynchronous external inputs.
REQ-012 out_port  output  DATA_WIDTH  output data register.
REQ-013 irq  output  1  active-high level interrupt.

Function
REQ-014 Write occurs on a rising clk edge with chipselect=1 and write_n=0; writedata bits at or above DATA_WIDTH are ignored.
REQ-015 Address map: 0 DATA (R: synced in_port; W: out register), 1 IRQMASK (R/W), 2 EDGECAP (R; W1C), 3 OUTSET (W: out |= wd), 4 OUTCLR (W: out &= ~wd), 5 OUTRB (R: out register); 6-7 read 0, writes ignored.
REQ-016 readdata is a combinational mux of the registers selected by address, zero-extended to 32 bits; reads have no side effects.
REQ-017 out_port equals the out register directly; a write is visible on out_port the cycle after the write edge.
REQ-018 in_port passes through a 2-FF synchronizer, plus a third "previous" stage for edge detection.
REQ-019 Edge detect compares sync stage 2 against the previous stage per EDGE_TYPE; a detected edge sets its EDGECAP bit on the next edge, i.e. the 3rd rising clk edge after in_port changes ahead of setup.
REQ-020 EDGECAP bits are sticky until cleared by writing 1 to that bit at address 2; writing 0 leaves a bit unchanged.
REQ-021 A W1C and a new edge on the same bit in the same cycle: the set wins and the bit stays 1.
REQ-022 irq = OR over (EDGECAP & IRQMASK), combinational from registers; it deasserts the cycle after the clearing write.
REQ-023 Writing IRQMASK does not alter EDGECAP; unmasking an already-captured bit asserts irq the next cycle.

Reset
REQ-024 On reset_n=0 asynchronously: out register = RESET_VALUE, IRQMASK = 0, EDGECAP = 0, synchronizer and previous stages = 0; irq = 0.
REQ-025 Nonzero in_port at reset release may produce a rising edge capture; this is intended behaviour.
REQ-026 Reset asserted mid-write discards the write.

Configuration
REQ-027 Macro LAB9_PIO_EDGE_IRQ_EN defined: edge capture, IRQMASK and irq are implemented as above.
REQ-028 Macro undefined: no edge/mask logic or previous stage; addresses 1 and 2 read 0 and ignore writes; irq tied 0; DATA read and out registers unchanged.

Structure
REQ-029 Package lab9_pio_pkg holds the register offset constants (ADDR_DATA..ADDR_OUTRB) and the edge-type enum (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-030 Sub-module lab9_pio_sync implements the per-bit synchronizer and edge detector, parameterised by DATA_WIDTH and EDGE_TYPE.

Verification
REQ-031 Reset with RESET_VALUE=32'h0000_00A5 -> out_port=32'hA5, readdata at address 5 = 32'hA5, irq=0.
REQ-032 Write 32'hF0F0_F0F0 to 0, then 32'h0000_000F to 3, then 32'hF000_0000 to 4 -> out_port = 32'h00F0_F0FF.
REQ-033 EDGE_TYPE=0, IRQMASK=32'h1, in_port bit0 0->1 -> EDGECAP=32'h1 on 3rd edge, irq=1 same cycle; write 32'h1 to 2 -> irq=0 next cycle.
REQ-034 New edge on bit0 in the same cycle as W1C of bit0 -> EDGECAP bit0 remains 1, irq stays 1.
REQ-035 DATA_WIDTH=8, write 32'hFFFF_FF3C to 0 -> out_port=8'h3C, address 5 reads 32'h0000_003C; address 7 reads 0.
REQ-036 Macro undefined, in_port toggling -> irq constant 0, address 2 reads 0, address 0 tracks in_port after 2 cycles.
